edge_event_arbiter: RTL

Collects the single-cycle `positiveedge`/`negativeedge` pulses from `channels` input conditioners and serializes them into one event stream. It uses a valid/ready handshake, so a downstream consumer (UI FSM, counter bank, bus interface) services one event at a time. Each channel has its own pending latches, so no pulse is lost while the consumer stalls. Channels are granted round-robin, and any event dropped due to an unserviced duplicate is reported through a sticky per-channel overflow flag.

---
 rtl/edgearb_pkg.sv | 20 ++
 rtl/edge_event_arbiter_rr_picker.sv | 38 +++
 rtl/edge_event_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/edgearb_pkg.sv
// ---------------------------------------------------------------------------
// edgearb_pkg
// Shared definitions for the edge event arbiter: edge-polarity encodings,
// the largest supported channel count and the round-robin pointer helper.
// ---------------------------------------------------------------------------
package edgearb_pkg;

    // Polarity encoding carried on eventrising
    localparam logic EDGE_RISE = 1'b1;
    localparam logic EDGE_FALL = 1'b0;

    // Largest number of conditioner channels the arbiter is built for
    localparam int unsigned MAX_CHANNELS = 16;

    // Index following idx in a ring of n entries (wraps n-1 -> 0)
    function automatic int unsigned next_rr(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/edge_event_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin picker. Scans the pending vector starting at
// rrptr, wrapping modulo channels, and reports the first set entry.
//   pending : per-channel "has something to serve" flags
//   rrptr   : index the scan starts from
//   grant   : index of the first pending channel at or after rrptr
//   found   : 1 when any channel is pending (grant is 0 otherwise)
// ---------------------------------------------------------------------------
module rr_picker
    import edgearb_pkg::*;
#(
    parameter int unsigned channels = 4,
    parameter int unsigned idwidth  = 2
) (
    input  logic [channels-1:0] pending,
    input  logic [idwidth-1:0]  rrptr,
    output logic [idwidth-1:0]  grant,
    output logic                found
);

    int unsigned idx;

    // Walk the ring once from rrptr; the first hit locks the grant
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < int'(channels); i++) begin
            idx = (32'(rrptr) + 32'(i)) % channels;
            if (!found && pending[idx]) begin
                found = 1'b1;
                grant = idwidth'(idx);
            end
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// edge_event_arbiter
// Collects single-cycle rising/falling pulses from several input
// conditioners and serializes them into one valid/ready event stream.
// Every channel keeps a rising and a falling pending latch plus an order bit,
// channels are served round-robin and dropped duplicates raise a sticky flag.
//   clk, resetn     : clock, asynchronous active-low reset
//   posedges        : per-channel rising-edge pulses
//   negedges        : per-channel falling-edge pulses
//   eventvalid      : event register holds an unconsumed event
//   eventready      : consumer takes the event when eventvalid is also high
//   eventchannel    : channel index of the presented event
//   eventrising     : 1 = rising edge, 0 = falling edge
//   overflow        : sticky per-channel "an event was dropped" flags
//   clearoverflow   : synchronous clear of all overflow flags
// ---------------------------------------------------------------------------
module edge_event_arbiter
    import edgearb_pkg::*;
#(
    parameter int unsigned channels = 4,
    parameter int unsigned idwidth  = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [channels-1:0] posedges,
    input  logic [channels-1:0] negedges,
    output logic                eventvalid,
    input  logic                eventready,
    output logic [idwidth-1:0]  eventchannel,
    output logic                eventrising,
    output logic [channels-1:0] overflow,
    input  logic                clearoverflow
);

    logic [channels-1:0] pendrise;
    logic [channels-1:0] pendfall;
    logic [channels-1:0] fallfirst;
    logic [idwidth-1:0]  rrptr;

    logic [channels-1:0] pendany;
    logic [idwidth-1:0]  grant;
    logic                found;
    logic                load;
    logic                serverise;
    logic [channels-1:0] clearrise;
    logic [channels-1:0] clearfall;
    logic [channels-1:0] risekept;
    logic [channels-1:0] fallkept;
    logic [channels-1:0] nextrise;
    logic [channels-1:0] nextfall;
    logic [channels-1:0] nextorder;
    logic [channels-1:0] ovfset;

    assign pendany = pendrise | pendfall;
    assign load    = !eventvalid || eventready;

    rr_picker #(
        .channels (channels),
        .idwidth  (idwidth)
    ) u_picker (
        .pending (pendany),
        .rrptr   (rrptr),
        .grant   (grant),
        .found   (found)
    );

    // Decide which latch of the granted channel is served this cycle: the
    // older one when both are set, otherwise whichever is set.
    always_comb begin
        serverise = pendrise[grant] && (!pendfall[grant] || !fallfirst[grant]);
        clearrise = '0;
        clearfall = '0;
        if (load && found) begin
            if (serverise) begin
                clearrise[grant] = 1'b1;
            end else begin
                clearfall[grant] = 1'b1;
            end
        end
    end

    // Next latch contents. A pulse onto a latch being served re-arms it as a
    // fresh event; a pulse onto a latch that survives is a dropped duplicate.
    // The order bit only matters when both latches end up set: a surviving
    // latch is older than a newly set one, and two new ones count rise first.
    always_comb begin
        risekept  = pendrise & ~clearrise;
        fallkept  = pendfall & ~clearfall;
        nextrise  = risekept | posedges;
        nextfall  = fallkept | negedges;
        ovfset    = (risekept & posedges) | (fallkept & negedges);
        nextorder = '0;
        for (int k = 0; k < int'(channels); k++) begin
            if (risekept[k] && fallkept[k]) begin
                nextorder[k] = fallfirst[k];
            end else if (fallkept[k] && posedges[k]) begin
                nextorder[k] = 1'b1;
            end else begin
                nextorder[k] = 1'b0;
            end
        end
    end

    // Pending latches, order bits and sticky overflow (set beats clear)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pendrise  <= '0;
            pendfall  <= '0;
            fallfirst <= '0;
            overflow  <= '0;
        end else begin
            pendrise  <= nextrise;
            pendfall  <= nextfall;
            fallfirst <= nextorder;
            overflow  <= (clearoverflow ? '0 : overflow) | ovfset;
        end
    end

    // Event register and round-robin pointer. On load the register takes the
    // granted event, or empties when nothing is pending; otherwise it holds.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            eventvalid   <= 1'b0;
            eventchannel <= '0;
            eventrising  <= EDGE_FALL;
            rrptr        <= '0;
        end else if (load) begin
            if (found) begin
                eventvalid   <= 1'b1;
                eventchannel <= grant;
                eventrising  <= serverise ? EDGE_RISE : EDGE_FALL;
                rrptr        <= idwidth'(next_rr(32'(grant), channels));
            end else begin
                eventvalid   <= 1'b0;
            end
        end
    end

endmodule
